// File: rtl/isu_pkg.sv
// Issue-unit shared definitions: ROB id layout, ROB state encoding and
// age-compare helpers used by the issue queues and the issue arbiter.
package isu_pkg;

    localparam int unsigned ROB_SIZE_LOG = 6;
    localparam int unsigned ROBID_LSB    = 241;
    localparam int unsigned ROBID_W      = ROB_SIZE_LOG + 1;

    typedef enum logic [1:0] {
        ROB_STATE_NORMAL    = 2'd0,
        ROB_STATE_WAIT      = 2'd1,
        ROB_STATE_ROLLIBACK = 2'd2,
        ROB_STATE_RSVD      = 2'd3
    } rob_state_e;

    // MSB is the wrap bit, the rest is the ROB index
    typedef logic [ROBID_W-1:0] robid_t;

    // a is older than b (ids in flight are never equal)
    function automatic logic robid_older(input robid_t a, input robid_t b);
        return a[ROB_SIZE_LOG] ^ b[ROB_SIZE_LOG]
             ^ (a[ROB_SIZE_LOG-1:0] < b[ROB_SIZE_LOG-1:0]);
    endfunction

    // e is strictly younger than the flush point f
    function automatic logic robid_younger(input robid_t e, input robid_t f);
        return f[ROB_SIZE_LOG] ^ e[ROB_SIZE_LOG]
             ^ (e[ROB_SIZE_LOG-1:0] > f[ROB_SIZE_LOG-1:0]);
    endfunction

endpackage

// File: rtl/isq_issue_sel.sv
// Combinational 2-way age select between the q0 (ALU) and q1 (MUL/DIV) heads.
// Ports:
//   en_i               selection permitted this cycle
//   q0_valid_i/data_i  q0 head
//   q1_valid_i/data_i  q1 head
//   q0_gnt_o/q1_gnt_o  one-hot-or-zero grant
//   data_o             payload of the picked head
//   src_o              0 = q0, 1 = q1
module isq_issue_sel
    import isu_pkg::*;
#(
    parameter int unsigned DATA_W = 248,
    parameter int unsigned ID_LSB = ROBID_LSB
) (
    input  logic              en_i,
    input  logic              q0_valid_i,
    input  logic [DATA_W-1:0] q0_data_i,
    input  logic              q1_valid_i,
    input  logic [DATA_W-1:0] q1_data_i,
    output logic              q0_gnt_o,
    output logic              q1_gnt_o,
    output logic [DATA_W-1:0] data_o,
    output logic              src_o
);

    robid_t id0;
    robid_t id1;
    logic   pick1;

    assign id0 = q0_data_i[ID_LSB +: ROBID_W];
    assign id1 = q1_data_i[ID_LSB +: ROBID_W];

    // q1 wins when it is alone or strictly older than q0
    assign pick1    = q1_valid_i && (!q0_valid_i || robid_older(id1, id0));
    assign q1_gnt_o = en_i && pick1;
    assign q0_gnt_o = en_i && q0_valid_i && !pick1;
    assign data_o   = pick1 ? q1_data_i : q0_data_i;
    assign src_o    = pick1;

endmodule

// File: rtl/isq_issue_arbiter.sv
// Shares one execute/issue port between the ALU queue (q0) and the MUL/DIV
// queue (q1). Picks the older ready head, registers it in a one-entry output
// stage, holds off selection while the unpipelined MUL/DIV unit is occupied,
// and kills a held instruction younger than the flush point on rollback.
// Ports:
//   clock, reset_n               clock, synchronous active-low reset
//   q0_deq_*/q1_deq_*            queue heads and dequeue acknowledges
//   iss_valid/iss_data/iss_src   registered output stage
//   iss_ready                    execute stage accepts iss_data
//   rob_state, flush_*           rollback flush request
//   port_busy                    MUL/DIV occupancy window active
module isq_issue_arbiter
    import isu_pkg::*;
#(
    parameter int unsigned DATA_W       = 248,
    parameter int unsigned ROBID_LSB    = isu_pkg::ROBID_LSB,
    parameter int unsigned ROB_SIZE_LOG = isu_pkg::ROB_SIZE_LOG,
    parameter int unsigned MULDIV_LAT   = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    q0_deq_valid,
    input  logic [DATA_W-1:0]       q0_deq_data,
    output logic                    q0_deq_ready,
    input  logic                    q1_deq_valid,
    input  logic [DATA_W-1:0]       q1_deq_data,
    output logic                    q1_deq_ready,
    output logic                    iss_valid,
    output logic [DATA_W-1:0]       iss_data,
    output logic                    iss_src,
    input  logic                    iss_ready,
    input  logic [1:0]              rob_state,
    input  logic                    flush_valid,
    input  logic [ROB_SIZE_LOG:0]   flush_robid,
    output logic                    port_busy
);

    localparam int unsigned CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CNT_W-1:0] BUSY_RELOAD = CNT_W'(MULDIV_LAT - 1);

    logic              iss_valid_q, iss_valid_d;
    logic [DATA_W-1:0] iss_data_q,  iss_data_d;
    logic              iss_src_q,   iss_src_d;
    logic [CNT_W-1:0]  busy_cnt_q,  busy_cnt_d;

    logic              kill;
    logic              can_load;
    logic              drain;
    logic              gnt0, gnt1;
    logic [DATA_W-1:0] sel_data;
    logic              sel_src;
    robid_t            held_id;

    assign kill     = flush_valid && (rob_state == ROB_STATE_ROLLIBACK);
    assign drain    = iss_valid_q && iss_ready;
    // reset_n gates selection so queues never see a handshake during reset
    assign can_load = reset_n && !kill && (busy_cnt_q == '0)
                   && (!iss_valid_q || iss_ready);
    assign held_id  = iss_data_q[ROBID_LSB +: ROBID_W];

    isq_issue_sel #(
        .DATA_W (DATA_W),
        .ID_LSB (ROBID_LSB)
    ) u_sel (
        .en_i       (can_load),
        .q0_valid_i (q0_deq_valid),
        .q0_data_i  (q0_deq_data),
        .q1_valid_i (q1_deq_valid),
        .q1_data_i  (q1_deq_data),
        .q0_gnt_o   (gnt0),
        .q1_gnt_o   (gnt1),
        .data_o     (sel_data),
        .src_o      (sel_src)
    );

    assign q0_deq_ready = gnt0;
    assign q1_deq_ready = gnt1;

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_data_d  = iss_data_q;
        iss_src_d   = iss_src_q;
        busy_cnt_d  = busy_cnt_q;

        if (gnt0 || gnt1) begin
            iss_valid_d = 1'b1;
            iss_data_d  = sel_data;
            iss_src_d   = sel_src;
        end else if (drain) begin
            iss_valid_d = 1'b0;
        end else if (kill && iss_valid_q && robid_younger(held_id, flush_robid)) begin
            iss_valid_d = 1'b0;
        end

        // a draining MUL/DIV op restarts the window even under a flush
        if (drain && iss_src_q) begin
            busy_cnt_d = BUSY_RELOAD;
        end else if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            iss_valid_q <= 1'b0;
            iss_data_q  <= '0;
            iss_src_q   <= 1'b0;
            busy_cnt_q  <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_data_q  <= iss_data_d;
            iss_src_q   <= iss_src_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_data  = iss_data_q;
    assign iss_src   = iss_src_q;
    assign port_busy = (busy_cnt_q != '0);

endmodule

// File: tb/tb_isq_issue_arbiter.sv
module tb_isq_issue_arbiter;
    import isu_pkg::*;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         q0_deq_valid, q1_deq_valid;
    logic [247:0] q0_deq_data, q1_deq_data;
    logic         q0_deq_ready, q1_deq_ready;
    logic         iss_valid, iss_src, iss_ready;
    logic [247:0] iss_data;
    logic [1:0]   rob_state;
    logic         flush_valid;
    logic [6:0]   flush_robid;
    logic         port_busy;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clock = ~clock;

    isq_issue_arbiter #(
        .DATA_W       (248),
        .ROBID_LSB    (241),
        .ROB_SIZE_LOG (6),
        .MULDIV_LAT   (4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .q0_deq_valid (q0_deq_valid),
        .q0_deq_data  (q0_deq_data),
        .q0_deq_ready (q0_deq_ready),
        .q1_deq_valid (q1_deq_valid),
        .q1_deq_data  (q1_deq_data),
        .q1_deq_ready (q1_deq_ready),
        .iss_valid    (iss_valid),
        .iss_data     (iss_data),
        .iss_src      (iss_src),
        .iss_ready    (iss_ready),
        .rob_state    (rob_state),
        .flush_valid  (flush_valid),
        .flush_robid  (flush_robid),
        .port_busy    (port_busy)
    );

    function automatic logic [247:0] mk(input logic [6:0] id, input logic [31:0] tag);
        logic [247:0] p;
        p = '0;
        p[247:241] = id;
        p[31:0]    = tag;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [247:0] got, input logic [247:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        q0_deq_valid = 1'b1; q0_deq_data = mk(7'h05, 32'h1);
        q1_deq_valid = 1'b0; q1_deq_data = '0;
        iss_ready = 1'b0; rob_state = ROB_STATE_NORMAL;
        flush_valid = 1'b0; flush_robid = '0;

        // reset
        tick(); tick();
        chk("rst_valid", 248'(iss_valid), 248'(0));
        chk("rst_data", iss_data, '0);
        chk("rst_src", 248'(iss_src), 248'(0));
        chk("rst_busy", 248'(port_busy), 248'(0));
        chk("rst_q0rdy", 248'(q0_deq_ready), 248'(0));

        // single q0 head, 1-cycle latency
        reset_n = 1'b1;
        settle();
        chk("t1_q0rdy", 248'(q0_deq_ready), 248'(1));
        chk("t1_q1rdy", 248'(q1_deq_ready), 248'(0));
        tick();
        chk("t1_valid", 248'(iss_valid), 248'(1));
        chk("t1_src", 248'(iss_src), 248'(0));
        chk("t1_data", iss_data, mk(7'h05, 32'h1));

        // age select: q1 0x02 older than q0 0x03 (drain+load)
        q0_deq_data = mk(7'h03, 32'h2);
        q1_deq_valid = 1'b1; q1_deq_data = mk(7'h02, 32'h3);
        iss_ready = 1'b1;
        settle();
        chk("t2_q1rdy", 248'(q1_deq_ready), 248'(1));
        chk("t2_q0rdy", 248'(q0_deq_ready), 248'(0));
        tick();
        chk("t2_data", iss_data, mk(7'h02, 32'h3));
        chk("t2_src", 248'(iss_src), 248'(1));

        // q1 op drains while q0 loads; busy window follows
        q1_deq_valid = 1'b0;
        settle();
        chk("t3_q0rdy_t", 248'(q0_deq_ready), 248'(1));
        tick();
        chk("t3_data", iss_data, mk(7'h03, 32'h2));
        chk("t3_busy1", 248'(port_busy), 248'(1));
        q0_deq_data = mk(7'h7E, 32'h5);
        q1_deq_valid = 1'b1; q1_deq_data = mk(7'h01, 32'h6);
        for (int i = 1; i <= 3; i++) begin
            settle();
            chk($sformatf("t3_busy_t%0d", i), 248'(port_busy), 248'(1));
            chk($sformatf("t3_q0rdy_t%0d", i), 248'(q0_deq_ready), 248'(0));
            chk($sformatf("t3_q1rdy_t%0d", i), 248'(q1_deq_ready), 248'(0));
            tick();
        end
        chk("t3_empty", 248'(iss_valid), 248'(0));
        settle();
        chk("t3_busy_t4", 248'(port_busy), 248'(0));
        chk("t3_wrap_q0rdy", 248'(q0_deq_ready), 248'(1));
        chk("t3_wrap_q1rdy", 248'(q1_deq_ready), 248'(0));
        tick();
        chk("t3_wrap_data", iss_data, mk(7'h7E, 32'h5));

        // stall: iss_ready low for 5 cycles
        q0_deq_data = mk(7'h10, 32'h7);
        q1_deq_data = mk(7'h11, 32'h8);
        iss_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("t4_stall_rdy%0d", i), 248'({q0_deq_ready, q1_deq_ready}), 248'(0));
            tick();
            chk($sformatf("t4_stall_data%0d", i), iss_data, mk(7'h7E, 32'h5));
        end
        iss_ready = 1'b1;
        settle();
        chk("t4_b2b_q0rdy", 248'(q0_deq_ready), 248'(1));
        tick();
        chk("t4_b2b_data0", iss_data, mk(7'h10, 32'h7));
        q0_deq_data = mk(7'h12, 32'h9);
        settle();
        chk("t4_b2b_q1rdy", 248'(q1_deq_ready), 248'(1));
        tick();
        chk("t4_b2b_data1", iss_data, mk(7'h11, 32'h8));
        chk("t4_b2b_src1", 248'(iss_src), 248'(1));
        q0_deq_valid = 1'b0; q1_deq_valid = 1'b0;
        tick();
        chk("t4_drain", 248'(iss_valid), 248'(0));
        tick(); tick(); tick();
        chk("t4_busy_clear", 248'(port_busy), 248'(0));

        // flush kills younger held entry
        q0_deq_valid = 1'b1; q0_deq_data = mk(7'h0A, 32'hA);
        iss_ready = 1'b0;
        tick();
        chk("t5_hold0A", 248'(iss_valid), 248'(1));
        q0_deq_valid = 1'b0;
        flush_valid = 1'b1; flush_robid = 7'h08; rob_state = ROB_STATE_ROLLIBACK;
        tick();
        chk("t5_kill0A", 248'(iss_valid), 248'(0));
        q0_deq_valid = 1'b1; q0_deq_data = mk(7'h07, 32'hB);
        settle();
        chk("t5_kill_gate", 248'(q0_deq_ready), 248'(0));
        flush_valid = 1'b0;
        settle();
        chk("t5_load07_rdy", 248'(q0_deq_ready), 248'(1));
        tick();
        q0_deq_valid = 1'b0;
        flush_valid = 1'b1;
        tick();
        chk("t5_keep07", 248'(iss_valid), 248'(1));
        chk("t5_keep07_data", iss_data, mk(7'h07, 32'hB));
        flush_robid = 7'h05; rob_state = ROB_STATE_NORMAL;
        tick();
        chk("t5_norollback", 248'(iss_valid), 248'(1));
        flush_valid = 1'b0;
        iss_ready = 1'b1;
        tick();
        chk("t5_drain07", 248'(iss_valid), 248'(0));

        // reset while HOLD with busy_cnt=2
        q1_deq_valid = 1'b1; q1_deq_data = mk(7'h30, 32'hC);
        iss_ready = 1'b0;
        tick();
        q1_deq_valid = 1'b0;
        q0_deq_valid = 1'b1; q0_deq_data = mk(7'h31, 32'hD);
        iss_ready = 1'b1;
        tick();
        q0_deq_valid = 1'b0; iss_ready = 1'b0;
        tick();
        chk("t6_hold", 248'(iss_valid), 248'(1));
        chk("t6_busy", 248'(port_busy), 248'(1));
        reset_n = 1'b0;
        q0_deq_valid = 1'b1;
        settle();
        chk("t6_rst_rdy_comb", 248'({q0_deq_ready, q1_deq_ready}), 248'(0));
        tick();
        chk("t6_rst_valid", 248'(iss_valid), 248'(0));
        chk("t6_rst_busy", 248'(port_busy), 248'(0));
        chk("t6_rst_data", iss_data, '0);
        chk("t6_rst_rdy", 248'({q0_deq_ready, q1_deq_ready}), 248'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
